// File: rtl/dec_trigger_ctl.sv
// Decode-stage PC-match trigger control: tdata1/tdata2 CSR state, match
// qualification/chaining/priority, sticky hits and TLU action handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dbg_mode                 core is in debug mode
//   csr_wr_*                 CSR write (sel, addr 0=tdata1 1=tdata2, data)
//   csr_rd_*                 CSR combinational read (0 for sel >= NUM_TRIG)
//   i0/i1_valid, _match      decode slot valid and raw per-trigger matches
//   trig_*                   per-trigger configuration to the match datapath
//   action_*                 registered action to TLU, req/ack handshake
//   stall_d                  hold decode while an action is pending
//
// Optional feature: define TRIGGER_CHAIN_EN to enable chained pairs (0,1),(2,3).
module dec_trigger_ctl #(
    parameter int NUM_TRIG = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbg_mode,
    input  logic                  csr_wr_en,
    input  logic [1:0]            csr_wr_sel,
    input  logic                  csr_wr_addr,
    input  logic [31:0]           csr_wr_data,
    input  logic [1:0]            csr_rd_sel,
    input  logic                  csr_rd_addr,
    output logic [31:0]           csr_rd_data,
    input  logic                  i0_valid,
    input  logic                  i1_valid,
    input  logic [NUM_TRIG-1:0]   i0_match,
    input  logic [NUM_TRIG-1:0]   i1_match,
    output logic [NUM_TRIG-1:0]   trig_select,
    output logic [NUM_TRIG-1:0]   trig_match,
    output logic [NUM_TRIG-1:0]   trig_execute,
    output logic [NUM_TRIG-1:0]   trig_m,
    output logic [32*NUM_TRIG-1:0] trig_tdata2,
    output logic                  action_req,
    output logic                  action_dbg,
    output logic                  action_i1,
    output logic [1:0]            action_idx,
    input  logic                  action_ack,
    output logic                  stall_d
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state;

    logic [NUM_TRIG-1:0] dmode;
    logic [NUM_TRIG-1:0] hit;
    logic [NUM_TRIG-1:0] select;
    logic [NUM_TRIG-1:0] action;
    logic [NUM_TRIG-1:0] chain;
    logic [NUM_TRIG-1:0] match;
    logic [NUM_TRIG-1:0] m;
    logic [NUM_TRIG-1:0] execute;
    logic [31:0]         tdata2 [NUM_TRIG];

    logic [NUM_TRIG-1:0] wr_t1;
    logic [NUM_TRIG-1:0] wr_t2;
    logic [NUM_TRIG-1:0] q0;
    logic [NUM_TRIG-1:0] q1;
    logic [NUM_TRIG-1:0] f0;
    logic [NUM_TRIG-1:0] f1;
    logic [NUM_TRIG-1:0] win;
    logic                win_i1;
    logic                win_dbg;
    logic [1:0]          win_idx;
    logic                fire;
    logic                new_dmode;

    // Only the fields above are stored; remaining data bits are dropped.
    logic unused_bits;
    assign unused_bits = ^csr_wr_data;

    assign trig_select  = select;
    assign trig_match   = match;
    assign trig_execute = execute;
    assign trig_m       = m;

    for (genvar g = 0; g < NUM_TRIG; g++) begin : g_td2
        assign trig_tdata2[32*g +: 32] = tdata2[g];
    end

    // A trigger owned by debug mode is locked against writes from M-mode.
    always_comb begin
        wr_t1 = '0;
        wr_t2 = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (csr_wr_en && csr_wr_sel == 2'(i) && !(dmode[i] && !dbg_mode)) begin
                wr_t1[i] = ~csr_wr_addr;
                wr_t2[i] = csr_wr_addr;
            end
        end
    end

    always_comb begin
        csr_rd_data = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (csr_rd_sel == 2'(i)) begin
                if (csr_rd_addr)
                    csr_rd_data = tdata2[i];
                else
                    csr_rd_data = {4'h2, dmode[i], 6'b0, hit[i], select[i],
                                   6'b0, action[i], chain[i], 3'b0,
                                   match[i], m[i], 3'b0, execute[i], 2'b0};
            end
        end
    end

    always_comb begin
        q0 = {NUM_TRIG{i0_valid & ~dbg_mode & (state == IDLE)}}
             & i0_match & execute & ~select;
        q1 = {NUM_TRIG{i1_valid & ~dbg_mode & (state == IDLE)}}
             & i1_match & execute & ~select;
        f0 = q0;
        f1 = q1;
`ifdef TRIGGER_CHAIN_EN
        // A chained pair fires as a unit, only when both match on one slot.
        for (int k = 0; k < NUM_TRIG / 2; k++) begin
            if (chain[2*k]) begin
                f0[2*k]   = q0[2*k] & q0[2*k+1];
                f0[2*k+1] = q0[2*k] & q0[2*k+1];
                f1[2*k]   = q1[2*k] & q1[2*k+1];
                f1[2*k+1] = q1[2*k] & q1[2*k+1];
            end
        end
`endif
        win_i1 = ~(|f0);
        win    = win_i1 ? f1 : f0;
        fire   = |win;
        win_idx = '0;
        win_dbg = 1'b0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (win[i]) begin
                win_idx = 2'(i);
                win_dbg = action[i];
            end
        end
    end

    assign new_dmode = dbg_mode ? csr_wr_data[27] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmode   <= '0;
            hit     <= '0;
            select  <= '0;
            action  <= '0;
            match   <= '0;
            m       <= '0;
            execute <= '0;
            for (int i = 0; i < NUM_TRIG; i++) tdata2[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (win[i]) hit[i] <= 1'b1;
                // Later assignment lets a same-cycle tdata1 write beat the hit.
                if (wr_t1[i]) begin
                    // Unlocked + dbg_mode=0 implies current dmode is 0.
                    dmode[i]   <= new_dmode;
                    action[i]  <= csr_wr_data[12] & new_dmode;
                    hit[i]     <= csr_wr_data[20];
                    select[i]  <= csr_wr_data[19];
                    match[i]   <= csr_wr_data[7];
                    m[i]       <= csr_wr_data[6];
                    execute[i] <= csr_wr_data[2];
                end
                if (wr_t2[i]) tdata2[i] <= csr_wr_data;
            end
        end
    end

`ifdef TRIGGER_CHAIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            for (int i = 0; i < NUM_TRIG; i++)
                if (wr_t1[i]) chain[i] <= csr_wr_data[11];
        end
    end
`else
    assign chain = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            action_req <= 1'b0;
            stall_d    <= 1'b0;
            action_dbg <= 1'b0;
            action_i1  <= 1'b0;
            action_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        state      <= REQ;
                        action_req <= 1'b1;
                        stall_d    <= 1'b1;
                        action_dbg <= win_dbg;
                        action_i1  <= win_i1;
                        action_idx <= win_idx;
                    end
                end
                REQ: begin
                    if (action_ack) begin
                        state      <= IDLE;
                        action_req <= 1'b0;
                        stall_d    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_trigger_ctl.sv
// Directed bench for dec_trigger_ctl with an action scoreboard.
module tb_dec_trigger_ctl;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic          dbg_mode;
    logic          csr_wr_en;
    logic [1:0]    csr_wr_sel;
    logic          csr_wr_addr;
    logic [31:0]   csr_wr_data;
    logic [1:0]    csr_rd_sel;
    logic          csr_rd_addr;
    logic [31:0]   csr_rd_data;
    logic          i0_valid;
    logic          i1_valid;
    logic [N-1:0]  i0_match;
    logic [N-1:0]  i1_match;
    logic [N-1:0]  trig_select;
    logic [N-1:0]  trig_match;
    logic [N-1:0]  trig_execute;
    logic [N-1:0]  trig_m;
    logic [32*N-1:0] trig_tdata2;
    logic          action_req;
    logic          action_dbg;
    logic          action_i1;
    logic [1:0]    action_idx;
    logic          action_ack;
    logic          stall_d;

    typedef struct packed {
        logic       dbg;
        logic       i1;
        logic [1:0] idx;
    } act_t;

    act_t sb[$];
    int   errors = 0;
    int   checks = 0;

    dec_trigger_ctl #(.NUM_TRIG(N)) dut (
        .clk(clk), .rst(rst), .dbg_mode(dbg_mode),
        .csr_wr_en(csr_wr_en), .csr_wr_sel(csr_wr_sel),
        .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .csr_rd_sel(csr_rd_sel), .csr_rd_addr(csr_rd_addr),
        .csr_rd_data(csr_rd_data),
        .i0_valid(i0_valid), .i1_valid(i1_valid),
        .i0_match(i0_match), .i1_match(i1_match),
        .trig_select(trig_select), .trig_match(trig_match),
        .trig_execute(trig_execute), .trig_m(trig_m),
        .trig_tdata2(trig_tdata2),
        .action_req(action_req), .action_dbg(action_dbg),
        .action_i1(action_i1), .action_idx(action_idx),
        .action_ack(action_ack), .stall_d(stall_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] sel, input logic addr,
                          input logic [31:0] data);
        csr_wr_en   = 1'b1;
        csr_wr_sel  = sel;
        csr_wr_addr = addr;
        csr_wr_data = data;
        @(negedge clk);
        csr_wr_en   = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [1:0] sel,
                           input logic addr, input logic [31:0] exp);
        csr_rd_sel  = sel;
        csr_rd_addr = addr;
        #1;
        check(tag, csr_rd_data, exp);
    endtask

    // One cycle of decode traffic; inputs cleared afterwards.
    task automatic drive(input logic [N-1:0] m0, input logic [N-1:0] m1);
        i0_valid = |m0;
        i1_valid = |m1;
        i0_match = m0;
        i1_match = m1;
        @(negedge clk);
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        i0_match = '0;
        i1_match = '0;
    endtask

    task automatic wait_action(input string tag);
        int   n;
        act_t e;
        n = 0;
        while (!action_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req"}, 32'(action_req), 32'd1);
        check({tag, " sb_pending"}, 32'(sb.size() != 0), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, " dbg"}, 32'(action_dbg), 32'(e.dbg));
        check({tag, " i1"}, 32'(action_i1), 32'(e.i1));
        check({tag, " idx"}, 32'(action_idx), 32'(e.idx));
        check({tag, " stall"}, 32'(stall_d), 32'd1);
    endtask

    task automatic ack(input string tag);
        action_ack = 1'b1;
        @(negedge clk);
        action_ack = 1'b0;
        check({tag, " req_after_ack"}, 32'(action_req), 32'd0);
        check({tag, " stall_after_ack"}, 32'(stall_d), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        dbg_mode = 1'b0;
        csr_wr_en = 1'b0;
        csr_wr_sel = '0;
        csr_wr_addr = 1'b0;
        csr_wr_data = '0;
        csr_rd_sel = '0;
        csr_rd_addr = 1'b0;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        i0_match = '0;
        i1_match = '0;
        action_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst req", 32'(action_req), 32'd0);
        check("rst stall", 32'(stall_d), 32'd0);
        csr_chk("rst t1_0", 2'd0, 1'b0, 32'h2000_0000);
        csr_chk("rst t1_3", 2'd3, 1'b0, 32'h2000_0000);
        csr_chk("rst t2_2", 2'd2, 1'b1, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single i0 breakpoint
        csr_wr(2'd0, 1'b1, 32'h0000_1000);
        csr_wr(2'd0, 1'b0, 32'h0000_0044);
        csr_chk("t1 cfg", 2'd0, 1'b0, 32'h2000_0044);
        csr_chk("t1 td2", 2'd0, 1'b1, 32'h0000_1000);
        check("t1 trig_td2", trig_tdata2[31:0], 32'h0000_1000);
        check("t1 trig_exe", 32'(trig_execute), 32'h1);
        sb.push_back('{dbg: 1'b0, i1: 1'b0, idx: 2'd0});
        drive(4'b0001, 4'b0000);
        wait_action("t1");
        csr_chk("t1 hit", 2'd0, 1'b0, 32'h2010_0044);
        @(negedge clk);
        @(negedge clk);
        check("t1 hold req", 32'(action_req), 32'd1);
        check("t1 hold idx", 32'(action_idx), 32'd0);
        ack("t1");

        // 2: i0 beats i1
        csr_wr(2'd1, 1'b0, 32'h0000_0044);
        csr_wr(2'd2, 1'b0, 32'h0000_0044);
        sb.push_back('{dbg: 1'b0, i1: 1'b0, idx: 2'd2});
        drive(4'b0100, 4'b0010);
        wait_action("t2");
        csr_chk("t2 hit2", 2'd2, 1'b0, 32'h2010_0044);
        csr_chk("t2 nohit1", 2'd1, 1'b0, 32'h2000_0044);
        ack("t2");

        // i1-only fire
        sb.push_back('{dbg: 1'b0, i1: 1'b1, idx: 2'd1});
        drive(4'b0000, 4'b0110);
        wait_action("t2b");
        ack("t2b");

        // 3: dmode/action protection
        csr_wr(2'd3, 1'b0, 32'h0800_1044);
        csr_chk("t3 nodbg", 2'd3, 1'b0, 32'h2000_0044);
        dbg_mode = 1'b1;
        csr_wr(2'd3, 1'b0, 32'h0800_1044);
        csr_chk("t3 dbg", 2'd3, 1'b0, 32'h2800_1044);
        dbg_mode = 1'b0;
        csr_wr(2'd3, 1'b0, 32'h0);
        csr_wr(2'd3, 1'b1, 32'hdead_beef);
        csr_chk("t3 locked", 2'd3, 1'b0, 32'h2800_1044);
        csr_chk("t3 locked_td2", 2'd3, 1'b1, 32'h0);
        dbg_mode = 1'b1;
        drive(4'b1000, 4'b0000);
        check("t3 dbgmode_nofire", 32'(action_req), 32'd0);
        dbg_mode = 1'b0;
        sb.push_back('{dbg: 1'b1, i1: 1'b0, idx: 2'd3});
        drive(4'b1000, 4'b0000);
        wait_action("t3");
        csr_chk("t3 hit", 2'd3, 1'b0, 32'h2810_1044);
        ack("t3");

        // 4: chaining
        csr_wr(2'd0, 1'b0, 32'h0000_0844);
        csr_wr(2'd1, 1'b0, 32'h0000_0044);
`ifdef TRIGGER_CHAIN_EN
        csr_chk("t4 chain", 2'd0, 1'b0, 32'h2000_0844);
        drive(4'b0001, 4'b0000);
        check("t4 alone", 32'(action_req), 32'd0);
        @(negedge clk);
        check("t4 alone2", 32'(action_req), 32'd0);
        sb.push_back('{dbg: 1'b0, i1: 1'b0, idx: 2'd0});
        drive(4'b0011, 4'b0000);
        wait_action("t4");
        csr_chk("t4 hit0", 2'd0, 1'b0, 32'h2010_0844);
        csr_chk("t4 hit1", 2'd1, 1'b0, 32'h2010_0044);
        ack("t4");
`else
        csr_chk("t4 nochain", 2'd0, 1'b0, 32'h2000_0044);
        sb.push_back('{dbg: 1'b0, i1: 1'b0, idx: 2'd0});
        drive(4'b0001, 4'b0000);
        wait_action("t4");
        csr_chk("t4 hit0", 2'd0, 1'b0, 32'h2010_0044);
        csr_chk("t4 nohit1", 2'd1, 1'b0, 32'h2000_0044);
        ack("t4");
`endif

        // 5: matches while in REQ and in the ack cycle are ignored
        csr_wr(2'd0, 1'b0, 32'h0000_0044);
        sb.push_back('{dbg: 1'b0, i1: 1'b0, idx: 2'd0});
        drive(4'b0001, 4'b0000);
        wait_action("t5");
        i0_valid = 1'b1;
        i0_match = 4'b0001;
        @(negedge clk);
        check("t5 wait req", 32'(action_req), 32'd1);
        action_ack = 1'b1;
        @(negedge clk);
        action_ack = 1'b0;
        i0_valid = 1'b0;
        i0_match = '0;
        check("t5 ack req", 32'(action_req), 32'd0);
        @(negedge clk);
        check("t5 no_second", 32'(action_req), 32'd0);
        action_ack = 1'b1;
        @(negedge clk);
        action_ack = 1'b0;
        check("t5 idle_ack", 32'(action_req), 32'd0);
        sb.push_back('{dbg: 1'b0, i1: 1'b0, idx: 2'd0});
        drive(4'b0001, 4'b0000);
        wait_action("t5b");

        // 6: async reset during REQ
        #2;
        rst = 1'b1;
        #1;
        check("t6 req", 32'(action_req), 32'd0);
        check("t6 stall", 32'(stall_d), 32'd0);
        csr_chk("t6 t1_0", 2'd0, 1'b0, 32'h2000_0000);
        csr_chk("t6 t1_3", 2'd3, 1'b0, 32'h2000_0000);
        csr_chk("t6 t2_0", 2'd0, 1'b1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6 post req", 32'(action_req), 32'd0);
        check("sb empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
